// File: rtl/toggle_arb_pkg.sv
// ============================================================================
//  Module      : toggle_arb_pkg
//  Description : Shared types, default parameters and a width helper for the
//                toggle arbiter and its round-robin picker.
//  Contents    : arb_state_t   - two-state arbiter FSM encoding
//                c_DEF_*       - default parameter values
//                c_HOLD_W      - width of the hold-window counter
//                idx_width()   - index width for an N-entry requester set
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toggle_arb_pkg;

    // Explicit one-bit encoding so the state register width is fixed.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int c_DEF_N_REQ       = 4;
    localparam int c_DEF_HOLD_CYCLES = 2;
    localparam int c_DEF_COUNT_W     = 8;

    // HOLD_CYCLES is bounded to 0..255, so eight bits always hold the load value.
    localparam int c_HOLD_W = 8;

    // Index width for pointers/owner fields; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority picker. Selects the first
//                set request at or above the pointer, wrapping to index 0.
//  Ports       : req    (in)  request vector
//                rr_ptr (in)  highest-priority index for this pick
//                valid  (out) at least one request is set
//                idx    (out) winner index (0 when no request)
//                onehot (out) one-hot winner (all zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_hi;
    logic [N_REQ-1:0] w_src;

    // Two-pass priority: requests at/above the pointer first; if none are set
    // there, the wrapped search is just the lowest set bit of the full vector.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_mask[i] = (IDX_W'(i) >= rr_ptr);
        end
        w_hi  = req & w_mask;
        w_src = (|w_hi) ? w_hi : req;
        valid = |req;

        // Scan downward so the lowest set bit is the last one written.
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                idx = IDX_W'(i);
            end
        end

        onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            onehot[i] = valid && (idx == IDX_W'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/toggle_arbiter.sv
// ============================================================================
//  Module      : toggle_arbiter
//  Description : Round-robin arbiter sharing one toggle bit among N_REQ
//                requesters. Every grant flips the bit once; a hold window of
//                HOLD_CYCLES keeps it stable before the next grant.
//  Ports       : clk        (in)  clock, rising edge
//                rst        (in)  asynchronous reset, active low
//                enable     (in)  permits new grants
//                req        (in)  level requests, one per requester
//                grant      (out) registered one-cycle one-hot grant
//                value      (out) shared toggle bit
//                last_owner (out) index of most recent grantee
//                flip_count (out) flips since reset, wrapping
//                busy       (out) high while holding after a flip
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_arbiter
    import toggle_arb_pkg::*;
#(
    parameter int N_REQ       = c_DEF_N_REQ,
    parameter int HOLD_CYCLES = c_DEF_HOLD_CYCLES,
    parameter int COUNT_W     = c_DEF_COUNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic                     value,
    output logic [$clog2(N_REQ)-1:0] last_owner,
    output logic [COUNT_W-1:0]       flip_count,
    output logic                     busy
);

    localparam int IDX_W = idx_width(N_REQ);

    // Counter starts at HOLD_CYCLES-1 so HOLD lasts exactly HOLD_CYCLES edges.
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD =
        (HOLD_CYCLES > 0) ? c_HOLD_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0]    c_LAST_IDX  = IDX_W'(N_REQ - 1);

    arb_state_t          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic [IDX_W-1:0]    r_ptr;
    logic [N_REQ-1:0]    r_grant;
    logic                r_value;
    logic [IDX_W-1:0]    r_owner;
    logic [COUNT_W-1:0]  r_count;

    logic                w_valid;
    logic [IDX_W-1:0]    w_idx;
    logic [N_REQ-1:0]    w_onehot;
    logic                w_fire;
    logic [IDX_W-1:0]    w_ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (r_ptr),
        .valid  (w_valid),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    assign w_fire     = enable && w_valid;
    // Explicit wrap keeps the pointer in range for non-power-of-two N_REQ.
    assign w_ptr_next = (w_idx == c_LAST_IDX) ? '0 : (w_idx + IDX_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_value <= 1'b0;
            r_owner <= '0;
            r_count <= '0;
        end else begin
            // Grant is a single-cycle pulse unless re-asserted below.
            r_grant <= '0;
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_grant <= w_onehot;
                        r_value <= ~r_value;
                        r_count <= r_count + COUNT_W'(1);
                        r_owner <= w_idx;
                        r_ptr   <= w_ptr_next;
                        // With no hold window the arbiter stays in IDLE and
                        // may grant again on the very next edge.
                        if (HOLD_CYCLES > 0) begin
                            r_state <= HOLD;
                            r_hold  <= c_HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (r_hold == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_hold <= r_hold - c_HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign value      = r_value;
    assign last_owner = r_owner;
    assign flip_count = r_count;
    assign busy       = (r_state == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_toggle_arbiter.sv
// ============================================================================
//  Module      : tb_toggle_arbiter
//  Description : Self-checking bench for toggle_arbiter. Two instances share
//                stimulus: default parameters and HOLD_CYCLES=0/COUNT_W=2.
//                Outputs are compared every cycle to a timeline-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] req = 4'b0;

    logic [3:0] g0, g1;
    logic       v0, v1;
    logic [1:0] o0, o1;
    logic [7:0] f0;
    logic [1:0] f1;
    logic       b0, b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    toggle_arbiter #(.N_REQ(4), .HOLD_CYCLES(2), .COUNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .grant(g0),
        .value(v0), .last_owner(o0), .flip_count(f0), .busy(b0)
    );

    toggle_arbiter #(.N_REQ(4), .HOLD_CYCLES(0), .COUNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .grant(g1),
        .value(v1), .last_owner(o1), .flip_count(f1), .busy(b1)
    );

    // Reference model: grants are tracked as points on an edge timeline.
    // A grant is allowed once more than HOLD edges have passed since the last
    // one; busy covers the HOLD edges starting at the grant edge.
    int m_hold [2] = '{2, 0};
    int m_cw   [2] = '{8, 2};
    int m_ptr  [2];
    int m_cnt  [2];
    int m_owner[2];
    int m_gidx [2];
    int m_lastg[2];
    bit m_have [2];
    int ecount = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_cnt[k] = 0; m_owner[k] = 0;
            m_gidx[k] = -1; m_lastg[k] = 0; m_have[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_gidx[k] = -1;
            if (enable && req != 4'b0 &&
                (!m_have[k] || (ecount - m_lastg[k]) > m_hold[k])) begin
                for (int off = 0; off < 4; off++) begin
                    int c;
                    c = (m_ptr[k] + off) % 4;
                    if (req[c] && m_gidx[k] < 0) m_gidx[k] = c;
                end
                m_cnt[k]++;
                m_owner[k] = m_gidx[k];
                m_ptr[k]   = (m_gidx[k] + 1) % 4;
                m_have[k]  = 1'b1;
                m_lastg[k] = ecount;
            end
        end
        ecount++;
    endtask

    function automatic logic [31:0] exp_grant(int k);
        return (m_gidx[k] >= 0) ? (32'd1 << m_gidx[k]) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_busy(int k);
        return (m_have[k] && (ecount - 1 - m_lastg[k]) < m_hold[k]) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_flip(int k);
        return 32'(m_cnt[k] % (1 << m_cw[k]));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("d0.grant", 32'(g0), exp_grant(0));
        chk("d0.value", 32'(v0), 32'(m_cnt[0] % 2));
        chk("d0.owner", 32'(o0), 32'(m_owner[0]));
        chk("d0.flip",  32'(f0), exp_flip(0));
        chk("d0.busy",  32'(b0), exp_busy(0));
        chk("d1.grant", 32'(g1), exp_grant(1));
        chk("d1.value", 32'(v1), 32'(m_cnt[1] % 2));
        chk("d1.owner", 32'(o1), 32'(m_owner[1]));
        chk("d1.flip",  32'(f1), exp_flip(1));
        chk("d1.busy",  32'(b1), exp_busy(1));
    endtask

    // One clock edge with current inputs, then check 1 time unit later.
    task automatic tick();
        if (!rst) model_reset();
        else      model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int hz_seq [4] = '{2, 3, 0, 1};

        // Reset state
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Single request from requester 0
        enable = 1'b1;
        req    = 4'b0001;
        tick();
        chk("tp1.grant", 32'(g0), 32'h1);
        chk("tp1.value", 32'(v0), 32'h1);
        req = 4'b0000;
        repeat (4) tick();

        // Round-robin fairness with all requesting
        req = 4'b1111;
        repeat (15) tick();

        // Pointer wrap with sparse requests
        req = 4'b0101;
        repeat (8) tick();

        // Enable gating
        req    = 4'b0000;
        repeat (3) tick();
        enable = 1'b0;
        req    = 4'b0010;
        repeat (5) tick();
        enable = 1'b1;
        tick();
        chk("gate.grant", 32'(g0), 32'h2);

        // Reset one cycle after a grant
        req = 4'b0000;
        repeat (4) tick();
        req = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1'b1;
        tick();
        chk("rst.first", 32'(g0), 32'h1);
        chk("hz.flip0", 32'(f1), 32'h1);

        // Zero hold: back-to-back grants and counter wrap on the second DUT
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hz.flip", 32'(f1), 32'(hz_seq[i]));
        end

        // Randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            req    = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                #2;
                model_reset();
                check_all();
                rst = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
